// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: load/store size encodings and FSM states.
package mem_wb_stage_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_lsu_align.sv
// Byte-lane handling for the data port: store strobes/lane replication,
// load byte/half extraction with sign or zero extension, and alignment check.
module mem_wb_stage_lsu_align
    import mem_wb_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        aligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        aligned   = (addr_lo == 2'b00);
        wstrb     = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        case (funct3)
            LS_B, LS_BU: begin
                aligned   = 1'b1;
                wstrb     = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = (funct3 == LS_B) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'b0, byte_sel};
            end
            LS_H, LS_HU: begin
                aligned   = ~addr_lo[0];
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = (funct3 == LS_H) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'b0, half_sel};
            end
            LS_W: begin
                aligned = (addr_lo == 2'b00);
            end
            // reserved sizes behave as word accesses
            default: begin
                aligned = (addr_lo == 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage of the RISC-V core: data-memory access with wait-state stall and
// timeout, followed by the MEM/WB pipeline register.
//
// state    | meaning
// ---------+----------------------------------------------------------
// MEM_IDLE | no access outstanding; zero-wait accesses complete here
// MEM_WAIT | access issued, waiting for dm_ready; upstream frozen
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_mem,
    input  logic [31:0] store_data_mem,
    input  logic [4:0]  rd_addr_mem,
    input  logic        wb_en_mem,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3_mem,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic        stall,
    output logic [31:0] fw_from_mem,
    output logic [31:0] wb_data_wb,
    output logic [4:0]  rd_addr_wb,
    output logic        wb_en_wb,
    output logic [31:0] fw_from_wb,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    mem_state_t    state;
    logic [CW-1:0] wait_cnt;

    logic        access;
    logic        aligned;
    logic        mem_op;
    logic        misalign;
    logic        timeout;
    logic        is_load;
    logic [3:0]  strb;
    logic [31:0] load_data;
    logic [31:0] wb_data_next;
    logic        wb_en_next;

    mem_wb_stage_lsu_align u_lsu_align (
        .addr_lo    (alu_out_mem[1:0]),
        .funct3     (funct3_mem),
        .store_data (store_data_mem),
        .rdata      (dm_rdata),
        .aligned    (aligned),
        .wstrb      (strb),
        .wdata      (dm_wdata),
        .load_data  (load_data)
    );

    assign access   = mem_read | mem_write;
    assign mem_op   = access & aligned;
    assign misalign = access & ~aligned;
    assign is_load  = mem_op & ~mem_write;
    assign timeout  = (state == MEM_WAIT) & mem_op & ~dm_ready & (wait_cnt == CNT_LAST);

    // upstream holds its inputs while stalled, so these stay stable through WAIT
    assign dm_req   = mem_op;
    assign dm_we    = mem_op & mem_write;
    assign dm_addr  = {alu_out_mem[31:2], 2'b00};
    assign dm_wstrb = dm_we ? strb : 4'b0000;
    assign stall    = mem_op & ~dm_ready & ~timeout;

    assign fw_from_mem = alu_out_mem;
    assign fw_from_wb  = wb_data_wb;

    assign wb_data_next = (is_load & dm_ready) ? load_data : alu_out_mem;
    assign wb_en_next   = wb_en_mem & (rd_addr_mem != 5'd0) & ~mem_write
                        & ~misalign & ~timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= MEM_IDLE;
            wait_cnt     <= '0;
            wb_data_wb   <= 32'd0;
            rd_addr_wb   <= 5'd0;
            wb_en_wb     <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= misalign;
            bus_err      <= timeout;
            if (!stall) begin
                wb_data_wb <= wb_data_next;
                rd_addr_wb <= rd_addr_mem;
                wb_en_wb   <= wb_en_next;
            end
            case (state)
                MEM_IDLE: begin
                    wait_cnt <= '0;
                    if (mem_op && !dm_ready) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (dm_ready || timeout || !mem_op) begin
                        state    <= MEM_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= MEM_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// transactions checked against a lane/extension reference model.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu_out_mem;
    logic [31:0] store_data_mem;
    logic [4:0]  rd_addr_mem;
    logic        wb_en_mem;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3_mem;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        stall;
    logic [31:0] fw_from_mem;
    logic [31:0] wb_data_wb;
    logic [4:0]  rd_addr_wb;
    logic        wb_en_wb;
    logic [31:0] fw_from_wb;
    logic        misalign_err;
    logic        bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    mem_wb_stage #(.TIMEOUT_CYC(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_out_mem    (alu_out_mem),
        .store_data_mem (store_data_mem),
        .rd_addr_mem    (rd_addr_mem),
        .wb_en_mem      (wb_en_mem),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3_mem     (funct3_mem),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wstrb       (dm_wstrb),
        .dm_wdata       (dm_wdata),
        .dm_rdata       (dm_rdata),
        .dm_ready       (dm_ready),
        .stall          (stall),
        .fw_from_mem    (fw_from_mem),
        .wb_data_wb     (wb_data_wb),
        .rd_addr_wb     (rd_addr_wb),
        .wb_en_wb       (wb_en_wb),
        .fw_from_wb     (fw_from_wb),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] word);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = (longint'(word) >> (8 * off)) & 255;
                if (f3 == 3'b000 && v > 127) v -= 256;
            end
            3'b001, 3'b101: begin
                v = (longint'(word) >> (8 * off)) & 65535;
                if (f3 == 3'b001 && v > 32767) v -= 65536;
            end
            default: v = longint'(word);
        endcase
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic wbe);
        mem_read       = rd_i;
        mem_write      = wr_i;
        funct3_mem     = f3;
        alu_out_mem    = addr;
        store_data_mem = sdata;
        rd_addr_mem    = rd;
        wb_en_mem      = wbe;
    endtask

    // Holds dm_ready low and counts stalled cycles until stall drops (bounded).
    task automatic stall_run(output int n);
        n = 0;
        dm_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        dm_ready = 1'b0;
        dm_rdata = 32'd0;
        tick();
        tick();
        n_chk++; if (wb_data_wb !== 32'd0) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", wb_data_wb); end
        n_chk++; if (rd_addr_wb !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rd_addr_wb); end
        n_chk++; if (wb_en_wb !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b want 0", wb_en_wb); end
        n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
        n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        n_chk++; if (dm_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_req_stall: got %b/%b want 0/0", dm_req, stall); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store_sw();
        set_op(0, 0, 3'b000, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
        dm_ready = 1'b1;
        tick();
        n_chk++; if (wb_en_wb !== 1'b1 || wb_data_wb !== 32'h1234) begin n_fail++; $display("FAIL alu_pre: got %b/%h want 1/00001234", wb_en_wb, wb_data_wb); end
        set_op(0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 1'b1);
        @(negedge clk);
        n_chk++; if (dm_req !== 1'b1 || dm_we !== 1'b1) begin n_fail++; $display("FAIL sw_req_we: got %b/%b want 1/1", dm_req, dm_we); end
        n_chk++; if (dm_wstrb !== 4'b1111) begin n_fail++; $display("FAIL sw_wstrb: got %b want 1111", dm_wstrb); end
        n_chk++; if (dm_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", dm_wdata); end
        n_chk++; if (dm_addr !== 32'h100 || fw_from_mem !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h/%h want 100", dm_addr, fw_from_mem); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %b want 0", stall); end
        tick();
        n_chk++; if (wb_en_wb !== 1'b0) begin n_fail++; $display("FAIL sw_wb_en: got %b want 0", wb_en_wb); end
        set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
    endtask

    task automatic test_lb_wait();
        int stalls;
        set_op(0, 0, 3'b000, 32'h0000_A5A5, 32'd0, 5'd3, 1'b1);
        dm_ready = 1'b1;
        tick();
        set_op(1, 0, 3'b000, 32'h0000_0103, 32'd0, 5'd9, 1'b1);
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            dm_ready = (c == 3);
            dm_rdata = (c == 3) ? 32'h8011_2233 : $urandom;
            @(negedge clk);
            if (stall) stalls++;
            n_chk++; if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'h100) begin n_fail++; $display("FAIL lb_req_c%0d: got req %b we %b addr %h want 1/0/100", c, dm_req, dm_we, dm_addr); end
            @(posedge clk);
            #1;
            if (c < 3) begin
                n_chk++; if (wb_data_wb !== 32'hA5A5 || rd_addr_wb !== 5'd3 || wb_en_wb !== 1'b1) begin n_fail++; $display("FAIL lb_hold_c%0d: got %h/%0d/%b want 0000a5a5/3/1", c, wb_data_wb, rd_addr_wb, wb_en_wb); end
            end
        end
        n_chk++; if (stalls != 3) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d want 3", stalls); end
        n_chk++; if (wb_data_wb !== 32'hFFFF_FF80 || fw_from_wb !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h/%h want ffffff80", wb_data_wb, fw_from_wb); end
        n_chk++; if (wb_en_wb !== 1'b1 || rd_addr_wb !== 5'd9) begin n_fail++; $display("FAIL lb_wb: got %b/%0d want 1/9", wb_en_wb, rd_addr_wb); end
        set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
    endtask

    task automatic test_lhu_sh();
        set_op(1, 0, 3'b101, 32'h0000_0102, 32'd0, 5'd4, 1'b1);
        dm_ready = 1'b1;
        dm_rdata = 32'hF00D_1234;
        @(negedge clk);
        n_chk++; if (stall !== 1'b0 || dm_wstrb !== 4'b0000) begin n_fail++; $display("FAIL lhu_stall_strb: got %b/%b want 0/0000", stall, dm_wstrb); end
        tick();
        n_chk++; if (wb_data_wb !== 32'h0000_F00D || wb_en_wb !== 1'b1) begin n_fail++; $display("FAIL lhu_data: got %h/%b want 0000f00d/1", wb_data_wb, wb_en_wb); end
        set_op(0, 1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 1'b0);
        @(negedge clk);
        n_chk++; if (dm_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb: got %b want 1100", dm_wstrb); end
        n_chk++; if (dm_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", dm_wdata); end
        tick();
        set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
    endtask

    task automatic test_misalign();
        set_op(1, 0, 3'b010, 32'h0000_0101, 32'd0, 5'd6, 1'b1);
        dm_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (dm_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL mis_req_stall: got %b/%b want 0/0", dm_req, stall); end
        tick();
        n_chk++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", misalign_err); end
        n_chk++; if (wb_en_wb !== 1'b0) begin n_fail++; $display("FAIL mis_wb_en: got %b want 0", wb_en_wb); end
        set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_len: got %b want 0", misalign_err); end
    endtask

    task automatic test_timeout();
        int n;
        for (int rep = 0; rep < 2; rep++) begin
            set_op(0, 0, 3'b000, 32'h0000_0042, 32'd0, 5'd8, 1'b1);
            dm_ready = 1'b1;
            tick();
            set_op(1, 0, 3'b010, 32'h0000_0200, 32'd0, 5'd8, 1'b1);
            stall_run(n);
            n_chk++; if (n != 16) begin n_fail++; $display("FAIL to_stall_cycles_r%0d: got %0d want 16", rep, n); end
            n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err_r%0d: got %b want 1", rep, bus_err); end
            n_chk++; if (wb_en_wb !== 1'b0) begin n_fail++; $display("FAIL to_wb_en_r%0d: got %b want 0", rep, wb_en_wb); end
            set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
            tick();
            n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse_len_r%0d: got %b want 0", rep, bus_err); end
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        set_op(0, 0, 3'b000, 32'h0000_0077, 32'd0, 5'd1, 1'b1);
        dm_ready = 1'b1;
        tick();
        set_op(1, 0, 3'b010, 32'h0000_0300, 32'd0, 5'd10, 1'b1);
        dm_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rw_pre_stall: got %b want 1", stall); end
        // the EX/MEM register upstream shares this reset, so its outputs clear too
        rst = 1'b1;
        set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        rst = 1'b0;
        n_chk++; if (dm_req !== 1'b0 || dm_we !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rw_outputs: got req %b we %b stall %b want 0", dm_req, dm_we, stall); end
        n_chk++; if (wb_data_wb !== 32'd0 || rd_addr_wb !== 5'd0 || wb_en_wb !== 1'b0) begin n_fail++; $display("FAIL rw_memwb: got %h/%0d/%b want 0", wb_data_wb, rd_addr_wb, wb_en_wb); end
        set_op(0, 0, 3'b000, 32'h0000_0055, 32'd0, 5'd2, 1'b1);
        tick();
        n_chk++; if (wb_data_wb !== 32'h55 || wb_en_wb !== 1'b1 || rd_addr_wb !== 5'd2) begin n_fail++; $display("FAIL rw_alu: got %h/%b/%0d want 55/1/2", wb_data_wb, wb_en_wb, rd_addr_wb); end
        set_op(1, 0, 3'b010, 32'h0000_0304, 32'd0, 5'd3, 1'b1);
        stall_run(n);
        n_chk++; if (n != 16) begin n_fail++; $display("FAIL rw_counter_clear: got %0d want 16", n); end
        set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        int kind, off, w, waits;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rword, exp_wdata, exp_data;
        logic [3:0]  exp_strb;
        logic [4:0]  rdv;
        logic        rdf, wrf, wbe, access, aligned, exp_req, exp_en, chk_data;
        for (int t = 0; t < 60; t++) begin
            kind  = $urandom_range(0, 2);
            addr  = $urandom;
            sdata = $urandom;
            rword = $urandom;
            rdv   = 5'($urandom_range(0, 31));
            wbe   = ($urandom_range(0, 7) != 0);
            waits = $urandom_range(0, 3);
            rdf = 1'b0;
            wrf = 1'b0;
            f3  = 3'($urandom_range(0, 7));
            if (kind == 1) begin
                rdf = 1'b1;
                f3  = ld_f3[$urandom_range(0, 4)];
            end else if (kind == 2) begin
                wrf = 1'b1;
                rdf = 1'($urandom_range(0, 1));
                f3  = st_f3[$urandom_range(0, 2)];
            end
            off = int'(addr[1:0]);
            w   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            access  = rdf | wrf;
            aligned = ((off % w) == 0);
            exp_req = access && aligned;
            if (!exp_req) waits = 0;
            exp_strb  = 4'b0000;
            exp_wdata = sdata;
            if (exp_req && wrf) begin
                if (w == 1) begin exp_strb = 4'(1 << off); exp_wdata = 32'(sdata[7:0]) * 32'h0101_0101; end
                else if (w == 2) begin exp_strb = 4'(3 << off); exp_wdata = 32'(sdata[15:0]) * 32'h0001_0001; end
                else exp_strb = 4'hF;
            end
            exp_en   = wbe && (rdv != 5'd0) && !wrf && !(access && !aligned);
            chk_data = !access || (exp_req && !wrf);
            exp_data = access ? ref_load(f3, off, rword) : addr;
            set_op(rdf, wrf, f3, addr, sdata, rdv, wbe);
            for (int c = 0; c <= waits; c++) begin
                dm_ready = (c == waits);
                dm_rdata = (c == waits) ? rword : $urandom;
                @(negedge clk);
                n_chk++; if (dm_req !== exp_req || stall !== (exp_req && c < waits)) begin n_fail++; $display("FAIL rnd%0d_req_stall: got %b/%b want %b/%b", t, dm_req, stall, exp_req, exp_req && c < waits); end
                if (exp_req) begin
                    n_chk++; if (dm_we !== wrf || dm_addr !== (addr & 32'hFFFF_FFFC) || dm_wstrb !== exp_strb) begin n_fail++; $display("FAIL rnd%0d_port: got we %b addr %h strb %b want %b %h %b", t, dm_we, dm_addr, dm_wstrb, wrf, addr & 32'hFFFF_FFFC, exp_strb); end
                    if (wrf) begin
                        n_chk++; if (dm_wdata !== exp_wdata) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", t, dm_wdata, exp_wdata); end
                    end
                end
                @(posedge clk);
                #1;
            end
            n_chk++; if (wb_en_wb !== exp_en || rd_addr_wb !== rdv) begin n_fail++; $display("FAIL rnd%0d_wb: got en %b rd %0d want %b %0d", t, wb_en_wb, rd_addr_wb, exp_en, rdv); end
            n_chk++; if (misalign_err !== (access && !aligned) || bus_err !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_err: got mis %b bus %b want %b 0", t, misalign_err, bus_err, access && !aligned); end
            if (chk_data) begin
                n_chk++; if (wb_data_wb !== exp_data || fw_from_wb !== exp_data) begin n_fail++; $display("FAIL rnd%0d_data: got %h want %h (f3 %b off %0d)", t, wb_data_wb, exp_data, f3, off); end
            end
        end
        set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        dm_ready = 1'b0;
        dm_rdata = 32'd0;
        set_op(0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        test_reset();
        test_store_sw();
        test_lb_wait();
        test_lhu_sh();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
